uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one `uart_tx` transmitter between `Ports` byte-stream requesters. Each requester offers bytes with a valid/ready handshake and marks the final byte of a frame with `req_last`. The arbiter grants one requester at a time in round-robin order and holds the grant for the whole frame. It sequences each byte into `uart_tx` through the `txen`/`cts` pair. It sits between firmware/debug sources and the shared `uart_tx` instance.

## Interface
- `Ports`, 4, number of requesters (2..8)
- `Timeout`, 1024, clock cycles a granted requester may leave `req_valid` low mid-frame before its grant is revoked (≥ 2)
- `clock` in 1: system clock
- `reset` in 1: synchronous, active-high
- `req_valid` in `Ports`: requester i has a byte on its slice of `req_data`
- `req_data` in `Ports*8`: byte of requester i at bits [8i+7:8i]
- `req_last` in `Ports`: offered byte is the last of its frame
- `req_ready` out `Ports`: one-cycle accept pulse for requester i's current byte
- `grant` out `Ports`: one-hot current owner; all zero when idle
- `busy` out 1: a frame is in progress
- `txen` out 1: to `uart_tx.txen`, registered, one-cycle start pulse
- `data` out 8: to `uart_tx.data`, registered, stable from the `txen` cycle until `cts` rises again
- `cts` in 1: from `uart_tx`; high when the transmitter is idle and can accept a byte

## Operation
- FSM states: IDLE, LOAD, START, BUSY, DONE.
- IDLE: if any `req_valid` is set, pick the winner by round robin, starting the search at `ptr`. Register `grant` and set `busy` = 1. Go to LOAD. Otherwise stay in IDLE.
- LOAD, case `req_valid[g] && cts`:
  - Pulse `req_ready[g]` combinationally in this cycle.
  - Register `data` ← slice g and `txen` ← 1.
  - Latch `last_q` ← `req_last[g]` and clear the timeout counter.
  - Go to START.
- LOAD, case `!req_valid[g]`: increment the timeout counter. When it reaches `Timeout` − 1, release (see below).
- START: `txen` is high for this cycle only. Go to BUSY.
- BUSY: wait for `cts` = 0, then go to DONE.
- DONE: wait for `cts` = 1. Then if `last_q` is set, release; otherwise go to LOAD.
- Release does the following:
  - `grant` ← 0 and `busy` ← 0.
  - `ptr` ← g+1, wrapping `Ports`−1 → 0.
  - Go to IDLE.
- While a grant is held, other requesters get no `req_ready`. Their `req_valid` is ignored and they are not starved past one frame each.
- If the granted requester drops `req_valid` mid-frame, the grant persists until timeout. After a timeout the remaining bytes of that frame are delivered as a new frame when it next wins.

## Timing
- Reset values: `txen` 0, `data` 0x00, `req_ready` 0, `grant` 0, `busy` 0, `ptr` 0, state IDLE, timeout counter 0.
- Reset mid-frame aborts immediately and returns to IDLE. No `req_ready` is issued in the reset cycle.
- Latency: `req_valid` rising in IDLE → `grant` next cycle → `req_ready`/`txen` registered in the following cycle, provided `cts` = 1. `txen` is visible to `uart_tx` on the third edge.
- Exactly one `req_ready` pulse per byte, and exactly one `txen` pulse per byte.
- `req_ready[i]` is never high unless `grant[i]` is high.
- Back-to-back bytes: the next LOAD is reached in the cycle after `cts` rises. There is no bubble beyond that cycle.
- Simultaneous requests in IDLE: the lowest index at or after `ptr` wins.
- `cts` already low on entry to LOAD: LOAD waits. The timeout counter does not run while `req_valid[g]` = 1.

## Structure
- Package `uart_pkg` holds the FSM state enum `uart_arb_state_t` and typedef `uart_byte_t` (logic [7:0]). It is shared with the `uart_tx`/`uart_rx` family.
- Sub-module `rr_picker`: combinational round-robin one-hot select from a `Ports`-bit request vector and a start pointer. It is reusable elsewhere.

## Test plan
- **Single frame:** requester 0 sends 0x5A, 0xA5 with `last` on 0xA5 (Clock 50 MHz, Baud 9600).
  - Two `txen` pulses occur, with `data` 0x5A then 0xA5.
  - `grant` = 0001 throughout, then 0000.
  - `txd` reproduces both bytes.
- **Contention:** requesters 1 and 2 both raise single-byte frames in IDLE with `ptr` = 0.
  - Requester 1 is served first, then requester 2.
  - `ptr` ends at 3.
- **Frame lock:** requester 3 sends a 3-byte frame while requester 0 is valid throughout.
  - Requester 0 gets no `req_ready` until requester 3's `last` byte completes.
- **Timeout:** with `Timeout` = 16, requester 2 sends 1 byte without `last`, then drops `req_valid`.
  - After `cts` returns high, `grant` clears 16 cycles later.
  - Requester 0, pending, is granted next.
- **Mid-frame reset:** assert `reset` during BUSY.
  - Next cycle: all outputs are at reset values and state is IDLE.
  - A fresh request afterwards is served normally.
- **Handshake invariants (assertions over random traffic):**
  - `req_ready` & ~`grant` == 0.
  - `txen` is high only when the previous cycle was LOAD with `cts` = 1.
  - The `req_ready` count equals the `txen` count.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the uart_tx / uart_rx family and the transmit arbiter.
// Holds the arbiter FSM encoding and the byte type used on the data path.
package uart_pkg;

   localparam int UART_BYTE_W = 8;

   typedef logic [UART_BYTE_W-1:0] uart_byte_t;

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_LOAD,
      ARB_START,
      ARB_BUSY,
      ARB_DONE
   } uart_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot select of the first
// request found at or after the start pointer, wrapping around.
module rr_picker #(
   parameter int Ports = 4
) (
   input  logic [Ports-1:0]         req,
   input  logic [$clog2(Ports)-1:0] ptr,
   output logic [Ports-1:0]         pick
);

   int   idx;
   logic found;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < Ports; k++) begin
         idx = int'(ptr) + k;
         if (idx >= Ports) begin
            idx = idx - Ports;
         end
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between byte-stream requesters.
// A grant is held for a whole frame, or until the owner stalls too long.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int Ports   = 4,
   parameter int Timeout = 1024
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [Ports-1:0]   req_valid,
   input  logic [Ports*8-1:0] req_data,
   input  logic [Ports-1:0]   req_last,
   output logic [Ports-1:0]   req_ready,
   output logic [Ports-1:0]   grant,
   output logic               busy,
   output logic               txen,
   output logic [7:0]         data,
   input  logic               cts
);

   localparam int PW = $clog2(Ports);
   localparam int TW = $clog2(Timeout);
   localparam logic [TW-1:0] TLAST = TW'(Timeout - 2);
   localparam logic [PW-1:0] PLAST = PW'(Ports - 1);

   uart_arb_state_t state_q, state_d;
   logic [Ports-1:0] grant_q, grant_d;
   logic             busy_q, busy_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic             txen_q, txen_d;
   uart_byte_t       data_q, data_d;
   logic             last_q, last_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;

   logic [Ports-1:0] pick;
   logic [PW-1:0]    gidx;
   logic [PW-1:0]    ptr_nxt;
   logic             sel_valid;
   logic             sel_last;
   uart_byte_t       sel_data;
   logic             release_g;

   rr_picker #(
      .Ports(Ports)
   ) u_pick (
      .req  (req_valid),
      .ptr  (ptr_q),
      .pick (pick)
   );

   always_comb begin
      gidx = '0;
      for (int k = 0; k < Ports; k++) begin
         if (grant_q[k]) begin
            gidx = PW'(k);
         end
      end
   end

   assign sel_valid = req_valid[gidx];
   assign sel_last  = req_last[gidx];
   assign sel_data  = req_data[{gidx, 3'b000} +: 8];
   assign ptr_nxt   = (gidx == PLAST) ? '0 : gidx + 1'b1;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      ptr_d     = ptr_q;
      txen_d    = 1'b0;
      data_d    = data_q;
      last_d    = last_q;
      tcnt_d    = tcnt_q;
      req_ready = '0;
      release_g = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (|req_valid) begin
               grant_d = pick;
               busy_d  = 1'b1;
               state_d = ARB_LOAD;
            end
         end
         ARB_LOAD: begin
            if (sel_valid) begin
               if (cts) begin
                  req_ready = grant_q;
                  data_d    = sel_data;
                  txen_d    = 1'b1;
                  last_d    = sel_last;
                  tcnt_d    = '0;
                  state_d   = ARB_START;
               end
            end else if (tcnt_q == TLAST) begin
               release_g = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ARB_START: begin
            state_d = ARB_BUSY;
         end
         ARB_BUSY: begin
            if (!cts) begin
               state_d = ARB_DONE;
            end
         end
         ARB_DONE: begin
            if (cts) begin
               if (last_q) begin
                  release_g = 1'b1;
               end else begin
                  state_d = ARB_LOAD;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
      if (release_g) begin
         grant_d = '0;
         busy_d  = 1'b0;
         ptr_d   = ptr_nxt;
         tcnt_d  = '0;
         state_d = ARB_IDLE;
      end
      // the abort cycle must not consume a byte
      if (reset) begin
         req_ready = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
         txen_q  <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         txen_q  <= txen_d;
         data_q  <= data_d;
         last_q  <= last_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;
   assign txen  = txen_q;
   assign data  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx cts model.
module tb_uart_tx_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic [3:0]  grant;
   logic        busy;
   logic        txen;
   logic [7:0]  data;
   logic        cts;

   int n_chk  = 0;
   int n_fail = 0;

   logic [8:0] mem [4][8];
   logic [3:0] pos [4];
   logic [3:0] len [4];
   logic [3:0] take = '0;

   int bcnt = 0;

   logic [7:0] tx_d [$];
   logic [3:0] tx_g [$];
   int         rdy_p [$];
   int         n_rdy = 0;
   int         n_txen = 0;
   int         viol_rg = 0;
   int         viol_tx = 0;
   logic       prev_rdy = 1'b0;

   uart_tx_arbiter #(
      .Ports   (4),
      .Timeout (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .busy      (busy),
      .txen      (txen),
      .data      (data),
      .cts       (cts)
   );

   always #5 clock = ~clock;

   for (genvar i = 0; i < 4; i++) begin : g_src
      assign req_valid[i]       = pos[i] < len[i];
      assign req_data[8*i +: 8] = mem[i][pos[i][2:0]][7:0];
      assign req_last[i]        = mem[i][pos[i][2:0]][8];
   end

   // transmitter stays busy for a few cycles after each start pulse
   always @(posedge clock) begin
      if (txen) bcnt <= 6;
      else if (bcnt != 0) bcnt <= bcnt - 1;
   end
   assign cts = (bcnt == 0);

   always @(negedge clock) begin
      take = req_ready;
      if ((req_ready & ~grant) != 4'b0) viol_rg++;
      if (txen && !prev_rdy) viol_tx++;
      prev_rdy = (req_ready != 4'b0);
      for (int i = 0; i < 4; i++) begin
         if (req_ready[i]) begin
            rdy_p.push_back(i);
            n_rdy++;
         end
      end
      if (txen) begin
         tx_d.push_back(data);
         tx_g.push_back(grant);
         n_txen++;
      end
   end

   always @(posedge clock) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         if (take[i]) pos[i] = pos[i] + 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nx();
      @(negedge clock);
      #1;
   endtask

   task automatic put(input int p, input logic [7:0] b, input logic l);
      mem[p][len[p][2:0]] = {l, b};
      len[p] = len[p] + 1'b1;
   endtask

   task automatic clr_log();
      tx_d.delete();
      tx_g.delete();
      rdy_p.delete();
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      do begin
         nx();
         k++;
      end while (!(busy == 1'b0 && req_valid == 4'b0) && k < budget);
      chk(tag, {busy, req_valid}, 0);
   endtask

   task automatic wait_tx(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (tx_d.size() < n && k < budget) begin
         nx();
         k++;
      end
      chk(tag, tx_d.size(), n);
   endtask

   task automatic wait_cts(input string tag, input logic v, input int budget);
      int k;
      k = 0;
      while (cts !== v && k < budget) begin
         nx();
         k++;
      end
      chk(tag, cts, v);
   endtask

   initial begin
      int k;
      for (int i = 0; i < 4; i++) begin
         pos[i] = '0;
         len[i] = '0;
         for (int j = 0; j < 8; j++) mem[i][j] = '0;
      end
      repeat (3) nx();
      chk("rst_txen", txen, 0);
      chk("rst_data", data, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      nx();

      // single frame with latency check
      clr_log();
      put(0, 8'h5A, 1'b0);
      put(0, 8'hA5, 1'b1);
      nx();
      chk("sf_grant", grant, 4'b0001);
      chk("sf_busy", busy, 1);
      chk("sf_ready", req_ready, 4'b0001);
      chk("sf_txen0", txen, 0);
      nx();
      chk("sf_txen", txen, 1);
      chk("sf_data", data, 8'h5A);
      chk("sf_ready_off", req_ready, 0);
      wait_idle("sf_idle", 100);
      chk("sf_count", tx_d.size(), 2);
      chk("sf_b0", tx_d[0], 8'h5A);
      chk("sf_b1", tx_d[1], 8'hA5);
      chk("sf_g0", tx_g[0], 4'b0001);
      chk("sf_g1", tx_g[1], 4'b0001);
      chk("sf_grant_end", grant, 0);

      // contention from ptr = 0
      reset = 1'b1;
      nx();
      reset = 1'b0;
      clr_log();
      put(1, 8'h11, 1'b1);
      put(2, 8'h22, 1'b1);
      wait_idle("ct_idle", 100);
      chk("ct_count", tx_d.size(), 2);
      chk("ct_b0", tx_d[0], 8'h11);
      chk("ct_g0", tx_g[0], 4'b0010);
      chk("ct_b1", tx_d[1], 8'h22);
      chk("ct_g1", tx_g[1], 4'b0100);

      // frame lock; ptr = 3 so requester 3 wins over 0
      clr_log();
      put(3, 8'h31, 1'b0);
      put(3, 8'h32, 1'b0);
      put(3, 8'h33, 1'b1);
      put(0, 8'h0F, 1'b1);
      wait_idle("fl_idle", 200);
      chk("fl_count", rdy_p.size(), 4);
      chk("fl_r0", rdy_p[0], 3);
      chk("fl_r1", rdy_p[1], 3);
      chk("fl_r2", rdy_p[2], 3);
      chk("fl_r3", rdy_p[3], 0);
      chk("fl_b2", tx_d[2], 8'h33);
      chk("fl_b3", tx_d[3], 8'h0F);

      // timeout; ptr = 1 so requester 2 wins over 0
      clr_log();
      put(2, 8'h2A, 1'b0);
      put(0, 8'h0A, 1'b1);
      wait_tx("to_tx", 1, 50);
      chk("to_g", tx_g[0], 4'b0100);
      wait_cts("to_cts_lo", 1'b0, 50);
      wait_cts("to_cts_hi", 1'b1, 50);
      k = 0;
      while (grant != 4'b0 && k < 40) begin
         nx();
         k++;
      end
      chk("to_cycles", k, 16);
      nx();
      chk("to_next", grant, 4'b0001);
      wait_idle("to_idle", 100);
      chk("to_b1", tx_d[1], 8'h0A);

      // reset while the transmitter is busy
      clr_log();
      put(1, 8'h77, 1'b0);
      put(1, 8'h78, 1'b1);
      wait_tx("mr_tx", 1, 50);
      nx();
      reset = 1'b1;
      nx();
      chk("mr_grant", grant, 0);
      chk("mr_busy", busy, 0);
      chk("mr_txen", txen, 0);
      chk("mr_data", data, 0);
      chk("mr_ready", req_ready, 0);
      reset = 1'b0;
      wait_idle("mr_idle", 100);
      chk("mr_count", tx_d.size(), 2);
      chk("mr_b1", tx_d[1], 8'h78);
      chk("mr_g1", tx_g[1], 4'b0010);

      // mixed traffic on all requesters
      clr_log();
      for (int p = 0; p < 4; p++) begin
         put(p, 8'($urandom), 1'b0);
         put(p, 8'($urandom), 1'b1);
      end
      wait_idle("rn_idle", 500);
      chk("rn_count", tx_d.size(), 8);
      for (int f = 0; f < 4; f++) begin
         chk("rn_lock", tx_g[2*f+1], tx_g[2*f]);
      end

      chk("inv_ready_grant", viol_rg, 0);
      chk("inv_txen_load", viol_tx, 0);
      chk("inv_ready_txen", n_rdy, n_txen);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
